// File: rtl/mdu_radix2_divider.sv
// mdu_radix2_divider
// Iterative restoring radix-2 divider serving MIPS DIV/DIVU. The responder
// side of the start/done mult-div handshake: a one-cycle start code in IDLE
// launches a fixed-latency divide (32 CALC steps plus one FIX step), and the
// result {HI=remainder, LO=quotient} is presented with done=1 until the next
// operation completes.
module mdu_radix2_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [1:0]         div_op,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] result,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] OP_SIGNED   = 2'b10;
  localparam logic [1:0] OP_UNSIGNED = 2'b01;

  // Architectural state
  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   rem_q;      // partial remainder
  logic [WIDTH-1:0]   quo_q;      // shifts out |dividend|, shifts in quotient bits
  logic [WIDTH-1:0]   dsor_q;     // |divisor|
  logic               signed_q;
  logic               neg_a_q;    // signed mode and dividend was negative
  logic               neg_b_q;    // signed mode and divisor was negative
  logic               div0_q;
  logic [2*WIDTH-1:0] result_q;
  logic               done_q;

  // Start decode and operand magnitudes (used only on the start edge)
  logic             start_any;
  logic             start_signed;
  logic             neg_a_d;
  logic             neg_b_d;
  logic [WIDTH-1:0] abs_a_d;
  logic [WIDTH-1:0] abs_b_d;

  // One restoring step
  logic [WIDTH:0]   rem_shift_d;
  logic [WIDTH:0]   trial_d;
  logic [WIDTH-1:0] rem_step_d;
  logic [WIDTH-1:0] quo_step_d;

  // Final sign correction
  logic [WIDTH-1:0] quo_fix_d;
  logic [WIDTH-1:0] rem_fix_d;

  // Decode the start code and form operand magnitudes. In signed mode a
  // negative operand is two's-complement negated; 0x80000000 negates to
  // itself, which is exactly its magnitude when read as unsigned.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned and no latch is inferred.
    start_signed = (div_op == OP_SIGNED);
    start_any    = (div_op == OP_SIGNED) || (div_op == OP_UNSIGNED);
    neg_a_d      = start_signed & dividend[WIDTH-1];
    neg_b_d      = start_signed & divisor[WIDTH-1];
    abs_a_d      = dividend;
    abs_b_d      = divisor;
    if (neg_a_d) abs_a_d = (~dividend) + WIDTH'(1);
    if (neg_b_d) abs_b_d = (~divisor) + WIDTH'(1);
  end

  // One iteration: shift {rem,quo} left, trial-subtract with a 33-bit compare,
  // keep the difference when non-negative, otherwise restore.
  // The extra top bit matters: the shifted remainder may exceed 2^WIDTH-1
  // while still being less than twice the divisor.
  always_comb begin
    rem_shift_d = {rem_q, quo_q[WIDTH-1]};
    trial_d     = rem_shift_d - {1'b0, dsor_q};
    rem_step_d  = rem_shift_d[WIDTH-1:0];
    quo_step_d  = {quo_q[WIDTH-2:0], 1'b0};
    if (!trial_d[WIDTH]) begin
      rem_step_d = trial_d[WIDTH-1:0];
      quo_step_d = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  // Sign correction applied in FIX. With a zero divisor every trial succeeds,
  // so the remainder ends as |dividend|; re-applying the dividend sign turns
  // it back into the raw dividend, and the quotient is forced to all ones.
  always_comb begin
    rem_fix_d = rem_q;
    quo_fix_d = quo_q;
    if (neg_a_q) rem_fix_d = (~rem_q) + WIDTH'(1);
    if (div0_q) begin
      quo_fix_d = '1;
    end else if (neg_a_q ^ neg_b_q) begin
      quo_fix_d = (~quo_q) + WIDTH'(1);
    end
  end

  // Control FSM and datapath registers: IDLE -> CALC (WIDTH steps) -> FIX -> IDLE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: non-blocking assignments throughout this block so every register
      // samples the pre-edge values of the others, independent of order.
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsor_q   <= '0;
      signed_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_any) begin
            signed_q <= start_signed;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            div0_q   <= (divisor == '0);
            rem_q    <= '0;
            quo_q    <= abs_a_d;
            dsor_q   <= abs_b_d;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            state_q  <= ST_CALC;
          end
        end
        ST_CALC: begin
          rem_q <= rem_step_d;
          quo_q <= quo_step_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          result_q <= {rem_fix_d, quo_fix_d};
          done_q   <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_mdu_radix2_divider.sv
// tb_mdu_radix2_divider
// Directed bench for the radix-2 divider: latency, signed/unsigned results,
// boundaries, divide by zero, busy-time starts, mid-operation reset and
// back-to-back operation with result hold.
module tb_mdu_radix2_divider;

  logic        clk;
  logic        resetn;
  logic [1:0]  div_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [63:0] result;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  mdu_radix2_divider #(.WIDTH(32)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .div_op   (div_op),
    .dividend (dividend),
    .divisor  (divisor),
    .result   (result),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation, optionally poke a fresh start code at step poke_at,
  // and check start response, latency, result hold and final result.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input logic [63:0] prev,
                        input int poke_at);
    int n;
    bit held;
    @(negedge clk);
    div_op   = op;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    check({tag, "_start"}, 64'(done), 64'd0);
    div_op   = 2'b00;
    dividend = 32'hDEADBEEF;
    divisor  = 32'h00000003;
    n    = 0;
    held = 1'b1;
    while (done !== 1'b1 && n < 100) begin
      if (result !== prev) held = 1'b0;
      @(posedge clk);
      #1;
      n++;
      if (n == poke_at) begin
        div_op   = 2'b01;
        dividend = 32'd5;
        divisor  = 32'd1;
      end else if (n == poke_at + 1) begin
        div_op = 2'b00;
      end
    end
    div_op = 2'b00;
    check({tag, "_latency"}, 64'(n), 64'd33);
    check({tag, "_hold"}, 64'(held), 64'd1);
    check({tag, "_result"}, result, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn   = 1'b0;
    div_op   = 2'b00;
    dividend = '0;
    divisor  = '0;
    #23;
    check("reset_done", 64'(done), 64'd1);
    check("reset_result", result, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Unsigned and signed basics
    run_op("u_100_7", 2'b01, 32'd100, 32'd7, 64'h00000002_0000000E, 64'd0, -1);
    run_op("s_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD,
           64'h00000002_0000000E, -1);
    run_op("s_7_m2", 2'b10, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD,
           64'hFFFFFFFF_FFFFFFFD, -1);
    run_op("s_m100_m7", 2'b10, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E,
           64'h00000001_FFFFFFFD, -1);

    // Boundaries
    run_op("s_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000,
           64'hFFFFFFFE_0000000E, -1);
    run_op("u_max_1", 2'b01, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF,
           64'h00000000_80000000, -1);

    // Divide by zero
    run_op("s_div0", 2'b10, 32'h12345678, 32'd0, 64'h12345678_FFFFFFFF,
           64'h00000000_FFFFFFFF, -1);
    run_op("s_div0_neg", 2'b10, 32'hFFFFFFFB, 32'd0, 64'hFFFFFFFB_FFFFFFFF,
           64'h12345678_FFFFFFFF, -1);
    run_op("u_div0", 2'b01, 32'h80000001, 32'd0, 64'h80000001_FFFFFFFF,
           64'hFFFFFFFB_FFFFFFFF, -1);

    // div_op=11 in IDLE is not a start
    @(negedge clk);
    div_op   = 2'b11;
    dividend = 32'd40;
    divisor  = 32'd2;
    @(posedge clk);
    #1;
    div_op = 2'b00;
    check("op11_done", 64'(done), 64'd1);
    check("op11_result", result, 64'h80000001_FFFFFFFF);

    // Start code while busy in CALC is ignored
    run_op("u_busy_poke", 2'b01, 32'd1000, 32'd10, 64'h00000000_00000064,
           64'h80000001_FFFFFFFF, 10);

    // Reset in the middle of an operation
    @(negedge clk);
    div_op   = 2'b01;
    dividend = 32'd50;
    divisor  = 32'd3;
    @(posedge clk);
    #1;
    div_op = 2'b00;
    repeat (20) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("midrst_done", 64'(done), 64'd1);
    check("midrst_result", result, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_idle", 64'(done), 64'd1);

    // Fresh op, then back-to-back op with a start code landing on the FIX edge
    run_op("u_9_3", 2'b01, 32'd9, 32'd3, 64'h00000000_00000003, 64'd0, -1);
    run_op("u_b2b_13_4", 2'b01, 32'd13, 32'd4, 64'h00000001_00000003,
           64'h00000000_00000003, 32);
    @(posedge clk);
    #1;
    check("fix_poke_idle", 64'(done), 64'd1);
    check("fix_poke_result", result, 64'h00000001_00000003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
